ibex_wb_queue: RTL and testbench
================================

Name: ibex_wb_queue

Overview:
- Multi-entry writeback stage for the CHERI Ibex pipeline. It sits between ID/EX and the register file.
- Holds up to Depth issued instructions in program order and tracks several outstanding loads/stores.
- Captures out-of-band LSU responses and retires at most one instruction per cycle, in order, with one RF write port (integer plus capability data).
- Generalises the single-entry writeback stage to a parametrised depth with per-entry completion tracking.

Parameters:
- Depth, 2, number of queue entries (legal 2..8).
- CheriCapWidth, 91, capability data width.
- CheriNullCap, 91'h0, value driven on pcc_wb_o when empty.
- ResetAll, 0, when 1 all payload flops are asynchronously reset; otherwise only valid/done/pointer state is reset.

Ports:
- clk_i in 1 clock
- rst_ni in 1 async active-low reset
- en_wb_i in 1 ID/EX offers an instruction
- instr_type_wb_i in 2 wb_instr_type_e (LOAD/STORE/OTHER)
- pc_id_i in 32 instruction PC
- pcc_id_i in CheriCapWidth instruction PCC
- instr_is_compressed_id_i in 1 compressed flag
- instr_perf_count_id_i in 1 counts toward retire counters
- rf_waddr_id_i in 5 destination register
- rf_we_id_i in 1 ID write enable
- rf_wcap_id_i in 1 ID write is a capability
- rf_wdata_int_id_i in 32 ID integer result
- rf_wdata_cap_id_i in CheriCapWidth ID capability result
- ready_wb_o out 1 entry accepted this cycle if en_wb_i
- lsu_resp_valid_i in 1 response for oldest un-done mem entry
- lsu_resp_err_i in 1 response is an error
- rf_we_lsu_i in 1 load writes RF
- rf_wcap_lsu_i in 1 load data is a capability
- rf_wdata_int_lsu_i in 32 load integer data
- rf_wdata_cap_lsu_i in CheriCapWidth load capability data
- rf_raddr_a_i in 5 ID read address A
- rf_raddr_b_i in 5 ID read address B
- hazard_a_o out 1 queue holds pending write to raddr A
- hazard_b_o out 1 queue holds pending write to raddr B
- rf_waddr_wb_o out 5 RF write address
- rf_we_wb_o out 1 RF write enable
- rf_wcap_wb_o out 1 RF write is a capability
- rf_wdata_int_wb_o out 32 RF integer write data
- rf_wdata_cap_wb_o out CheriCapWidth RF capability write data
- instr_done_wb_o out 1 head retired this cycle
- pc_wb_o out 32 head PC
- pcc_wb_o out CheriCapWidth head PCC
- outstanding_load_wb_o out 1 any valid un-done LOAD entry
- outstanding_store_wb_o out 1 any valid un-done STORE entry
- occupancy_o out $clog2(Depth+1) valid entry count
- perf_instr_ret_wb_o out 1 retire counter increment
- perf_instr_ret_compressed_wb_o out 1 compressed retire increment

Behaviour:
- Reset:
  - valid, done and err flags clear; head, tail and mem pointers = 0.
  - All outputs 0; pcc_wb_o = CheriNullCap.
  - A reset mid-operation drops all entries and pending responses.
- Entry state: valid, done, err, type, waddr, we, wcap, wdata_int, wdata_cap, pc, pcc, compressed, count.
- Enqueue:
  - Occurs when en_wb_i & ready_wb_o; writes the tail entry; tail advances mod Depth.
  - OTHER entries enter with done=1. LOAD/STORE entries enter with done=0.
  - ready_wb_o = (occupancy < Depth) | retire. When full, simultaneous retire and enqueue is allowed.
- LSU response:
  - Targets the oldest valid entry with done=0 and type != OTHER (mem pointer).
  - Sets done=1 and err=lsu_resp_err_i.
  - For a LOAD without error, overwrites we/wcap/wdata with the LSU inputs. A LOAD with error sets we=0.
  - A response with no eligible entry is illegal (assertion).
- Retire:
  - retire = head valid & (head done | LSU response targeting head this cycle).
  - Same-cycle response at head uses LSU inputs combinationally: zero-latency path.
  - On retire: instr_done_wb_o=1, RF outputs driven from the head (or LSU bypass), head advances.
  - rf_we_wb_o = retire & effective we; rf_wdata_* are 0 when rf_we_wb_o=0.
  - At most one retire per cycle.
- Hazards: hazard_x_o = raddr != 0 & any valid, not-retiring entry with waddr == raddr & (we | type == LOAD).
- Pointer wrap: all pointers wrap mod Depth, including non-power-of-2 Depth.
- occupancy_o is updated next cycle: +1 on enqueue, -1 on retire, net 0 when both occur.

Optional Feature:
- Macro IBEX_WB_QUEUE_PERF_EN.
- Defined:
  - perf_instr_ret_wb_o = retire & head count & ~effective err.
  - perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head compressed.
- Undefined: both outputs tied to 0, and the count/compressed flops are removed.

Test Plan:
- Enqueue OTHER x3 (waddr 1,2,3, data 0x11,0x22,0x33), Depth=2 -> ready_wb_o=0 on the 3rd offer only while no retire occurs; rf_we_wb_o retires 0x11, 0x22, 0x33 on consecutive cycles; occupancy_o returns to 0.
- Two LOADs (x5, x6) enqueued back-to-back; responses 0xAA then 0xBB two cycles later -> x5=0xAA and x6=0xBB written in order; outstanding_load_wb_o=1 until the 2nd response.
- LOAD x7 at head, response 0xCAFE with rf_wcap_lsu_i=1 in the same cycle -> rf_we_wb_o=1, rf_wcap_wb_o=1, wdata 0xCAFE that cycle, zero latency.
- LOAD x8 with lsu_resp_err_i=1 -> instr_done_wb_o=1, rf_we_wb_o=0, perf_instr_ret_wb_o=0 (macro on).
- STORE then OTHER x9 -> OTHER waits behind STORE; hazard_a_o=1 for raddr 9, 0 for raddr 0.
- Reset asserted with 2 pending loads, then a late response -> no RF write; occupancy_o=0.

Source files
------------

// File: rtl/ibex_wb_queue.sv
// Multi-entry, in-order writeback queue between ID/EX and the register file (CHERI Ibex).
// Define IBEX_WB_QUEUE_PERF_EN to enable the retire performance-counter outputs.
module ibex_wb_queue #(
  parameter int unsigned              Depth         = 2,
  parameter int unsigned              CheriCapWidth = 91,
  parameter logic [CheriCapWidth-1:0] CheriNullCap  = '0,
  parameter bit                       ResetAll      = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_wb_i,
  input  logic [1:0]                   instr_type_wb_i,
  input  logic [31:0]                  pc_id_i,
  input  logic [CheriCapWidth-1:0]     pcc_id_i,
  input  logic                         instr_is_compressed_id_i,
  input  logic                         instr_perf_count_id_i,
  input  logic [4:0]                   rf_waddr_id_i,
  input  logic                         rf_we_id_i,
  input  logic                         rf_wcap_id_i,
  input  logic [31:0]                  rf_wdata_int_id_i,
  input  logic [CheriCapWidth-1:0]     rf_wdata_cap_id_i,
  output logic                         ready_wb_o,
  input  logic                         lsu_resp_valid_i,
  input  logic                         lsu_resp_err_i,
  input  logic                         rf_we_lsu_i,
  input  logic                         rf_wcap_lsu_i,
  input  logic [31:0]                  rf_wdata_int_lsu_i,
  input  logic [CheriCapWidth-1:0]     rf_wdata_cap_lsu_i,
  input  logic [4:0]                   rf_raddr_a_i,
  input  logic [4:0]                   rf_raddr_b_i,
  output logic                         hazard_a_o,
  output logic                         hazard_b_o,
  output logic [4:0]                   rf_waddr_wb_o,
  output logic                         rf_we_wb_o,
  output logic                         rf_wcap_wb_o,
  output logic [31:0]                  rf_wdata_int_wb_o,
  output logic [CheriCapWidth-1:0]     rf_wdata_cap_wb_o,
  output logic                         instr_done_wb_o,
  output logic [31:0]                  pc_wb_o,
  output logic [CheriCapWidth-1:0]     pcc_wb_o,
  output logic                         outstanding_load_wb_o,
  output logic                         outstanding_store_wb_o,
  output logic [$clog2(Depth+1)-1:0]   occupancy_o,
  output logic                         perf_instr_ret_wb_o,
  output logic                         perf_instr_ret_compressed_wb_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned OccW = $clog2(Depth+1);
  localparam logic [1:0] WbLoad  = 2'b00;
  localparam logic [1:0] WbOther = 2'b10;

  typedef struct packed {
    logic [1:0]               typ;
    logic [4:0]               waddr;
    logic                     we;
    logic                     wcap;
    logic [31:0]              wdata_int;
    logic [CheriCapWidth-1:0] wdata_cap;
    logic [31:0]              pc;
    logic [CheriCapWidth-1:0] pcc;
`ifdef IBEX_WB_QUEUE_PERF_EN
    logic                     compressed;
    logic                     count;
`endif
  } entry_t;

  logic [Depth-1:0] valid_q, valid_d, done_q, done_d, err_q, err_d;
  entry_t           ent_q [Depth];
  entry_t           ent_d [Depth];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d, mem_ptr, scan_idx;
  logic [OccW-1:0]  occ_q, occ_d;
  logic             mem_found, resp_fire, resp_at_head, head_valid, retire, enq;
  logic             eff_err, eff_we, eff_wcap, hz_a, hz_b, live, writes;
  logic [31:0]              eff_int;
  logic [CheriCapWidth-1:0] eff_cap;
  entry_t           head_ent;

  // Wraps correctly for non-power-of-two Depth; n is always below Depth.
  function automatic logic [PtrW-1:0] ptr_add(logic [PtrW-1:0] p, int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= Depth) s = s - Depth;
    return PtrW'(s);
  endfunction

  // The next LSU response belongs to the oldest un-done memory entry.
  always_comb begin
    mem_found = 1'b0;
    mem_ptr   = head_q;
    scan_idx  = head_q;
    for (int unsigned i = 0; i < Depth; i++) begin
      scan_idx = ptr_add(head_q, i);
      if (!mem_found && valid_q[scan_idx] && !done_q[scan_idx] && ent_q[scan_idx].typ != WbOther) begin
        mem_found = 1'b1;
        mem_ptr   = scan_idx;
      end
    end
  end

  assign head_ent     = ent_q[head_q];
  assign head_valid   = valid_q[head_q];
  assign resp_fire    = lsu_resp_valid_i & mem_found;
  assign resp_at_head = resp_fire & (mem_ptr == head_q);
  assign retire       = head_valid & (done_q[head_q] | resp_at_head);
  assign ready_wb_o   = (occ_q < OccW'(Depth)) | retire;
  assign enq          = en_wb_i & ready_wb_o;

  always_comb begin
    eff_err  = err_q[head_q];
    eff_we   = head_ent.we;
    eff_wcap = head_ent.wcap;
    eff_int  = head_ent.wdata_int;
    eff_cap  = head_ent.wdata_cap;
    if (resp_at_head) begin
      eff_err = lsu_resp_err_i;
      if (head_ent.typ == WbLoad) begin
        eff_we = rf_we_lsu_i & ~lsu_resp_err_i;
        if (!lsu_resp_err_i) begin
          eff_wcap = rf_wcap_lsu_i;
          eff_int  = rf_wdata_int_lsu_i;
          eff_cap  = rf_wdata_cap_lsu_i;
        end
      end
    end
  end

  assign instr_done_wb_o   = retire;
  assign rf_we_wb_o        = retire & eff_we;
  assign rf_wcap_wb_o      = rf_we_wb_o & eff_wcap;
  assign rf_waddr_wb_o     = retire ? head_ent.waddr : 5'd0;
  assign rf_wdata_int_wb_o = rf_we_wb_o ? eff_int : 32'd0;
  assign rf_wdata_cap_wb_o = rf_we_wb_o ? eff_cap : '0;
  assign pc_wb_o           = head_valid ? head_ent.pc : 32'd0;
  assign pcc_wb_o          = head_valid ? head_ent.pcc : CheriNullCap;
  assign occupancy_o       = occ_q;

  // A retiring head no longer blocks readers: its value reaches the RF this cycle.
  always_comb begin
    hz_a = 1'b0;
    hz_b = 1'b0;
    live = 1'b0;
    writes = 1'b0;
    outstanding_load_wb_o  = 1'b0;
    outstanding_store_wb_o = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      live   = valid_q[i] & ~(retire & (PtrW'(i) == head_q));
      writes = ent_q[i].we | (ent_q[i].typ == WbLoad);
      if (live && writes && (ent_q[i].waddr == rf_raddr_a_i)) hz_a = 1'b1;
      if (live && writes && (ent_q[i].waddr == rf_raddr_b_i)) hz_b = 1'b1;
      if (valid_q[i] && !done_q[i] && ent_q[i].typ == WbLoad) outstanding_load_wb_o = 1'b1;
      if (valid_q[i] && !done_q[i] && ent_q[i].typ == 2'b01) outstanding_store_wb_o = 1'b1;
    end
  end
  assign hazard_a_o = hz_a & (rf_raddr_a_i != 5'd0);
  assign hazard_b_o = hz_b & (rf_raddr_b_i != 5'd0);

  // Retire clears the head before enqueue so a full queue can refill the same slot.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    err_d   = err_q;
    ent_d   = ent_q;
    if (resp_fire) begin
      done_d[mem_ptr] = 1'b1;
      err_d[mem_ptr]  = lsu_resp_err_i;
      if (ent_q[mem_ptr].typ == WbLoad) begin
        ent_d[mem_ptr].we = rf_we_lsu_i & ~lsu_resp_err_i;
        if (!lsu_resp_err_i) begin
          ent_d[mem_ptr].wcap      = rf_wcap_lsu_i;
          ent_d[mem_ptr].wdata_int = rf_wdata_int_lsu_i;
          ent_d[mem_ptr].wdata_cap = rf_wdata_cap_lsu_i;
        end
      end
    end
    if (retire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      err_d[head_q]   = 1'b0;
    end
    if (enq) begin
      valid_d[tail_q]         = 1'b1;
      done_d[tail_q]          = (instr_type_wb_i == WbOther);
      err_d[tail_q]           = 1'b0;
      ent_d[tail_q].typ       = instr_type_wb_i;
      ent_d[tail_q].waddr     = rf_waddr_id_i;
      ent_d[tail_q].we        = rf_we_id_i;
      ent_d[tail_q].wcap      = rf_wcap_id_i;
      ent_d[tail_q].wdata_int = rf_wdata_int_id_i;
      ent_d[tail_q].wdata_cap = rf_wdata_cap_id_i;
      ent_d[tail_q].pc        = pc_id_i;
      ent_d[tail_q].pcc       = pcc_id_i;
`ifdef IBEX_WB_QUEUE_PERF_EN
      ent_d[tail_q].compressed = instr_is_compressed_id_i;
      ent_d[tail_q].count      = instr_perf_count_id_i;
`endif
    end
  end

  assign head_d = retire ? ptr_add(head_q, 1) : head_q;
  assign tail_d = enq ? ptr_add(tail_q, 1) : tail_q;
  assign occ_d  = occ_q + OccW'(enq) - OccW'(retire);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
    end
  end

  if (ResetAll) begin : g_payload_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < Depth; i++) ent_q[i] <= '0;
      end else begin
        ent_q <= ent_d;
      end
    end
  end else begin : g_payload_nrst
    always_ff @(posedge clk_i) begin
      ent_q <= ent_d;
    end
  end

`ifdef IBEX_WB_QUEUE_PERF_EN
  assign perf_instr_ret_wb_o            = retire & head_ent.count & ~eff_err;
  assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head_ent.compressed;
`else
  logic unused_perf;
  assign unused_perf = ^{instr_is_compressed_id_i, instr_perf_count_id_i, eff_err};
  assign perf_instr_ret_wb_o            = 1'b0;
  assign perf_instr_ret_compressed_wb_o = 1'b0;
`endif

  resp_has_target_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lsu_resp_valid_i |-> mem_found);

endmodule

// File: tb/tb_ibex_wb_queue.sv
// Bench for ibex_wb_queue: directed scenarios plus random traffic against a queue-based model.
module tb_ibex_wb_queue;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 91;
  localparam int unsigned OCCW  = $clog2(DEPTH+1);
  localparam logic [CW-1:0] NULLCAP = '0;
  localparam logic [1:0] T_LOAD = 2'b00, T_STORE = 2'b01, T_OTHER = 2'b10;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic en_wb_i, instr_is_compressed_id_i, instr_perf_count_id_i, rf_we_id_i, rf_wcap_id_i;
  logic [1:0] instr_type_wb_i;
  logic [31:0] pc_id_i, rf_wdata_int_id_i, rf_wdata_int_lsu_i;
  logic [CW-1:0] pcc_id_i, rf_wdata_cap_id_i, rf_wdata_cap_lsu_i;
  logic [4:0] rf_waddr_id_i, rf_raddr_a_i, rf_raddr_b_i;
  logic lsu_resp_valid_i, lsu_resp_err_i, rf_we_lsu_i, rf_wcap_lsu_i;
  logic ready_wb_o, hazard_a_o, hazard_b_o, rf_we_wb_o, rf_wcap_wb_o, instr_done_wb_o;
  logic outstanding_load_wb_o, outstanding_store_wb_o, perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o;
  logic [4:0] rf_waddr_wb_o;
  logic [31:0] rf_wdata_int_wb_o, pc_wb_o;
  logic [CW-1:0] rf_wdata_cap_wb_o, pcc_wb_o;
  logic [OCCW-1:0] occupancy_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] typ; logic [4:0] waddr; logic we; logic wcap;
    logic [31:0] di; logic [CW-1:0] dc; logic [31:0] pc; logic [CW-1:0] pcc;
    logic cmp; logic cnt; logic done; logic err;
  } mentry_t;
  mentry_t mq[$];

  ibex_wb_queue #(.Depth(DEPTH), .CheriCapWidth(CW), .CheriNullCap(NULLCAP), .ResetAll(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_wb_i(en_wb_i), .instr_type_wb_i(instr_type_wb_i),
    .pc_id_i(pc_id_i), .pcc_id_i(pcc_id_i), .instr_is_compressed_id_i(instr_is_compressed_id_i),
    .instr_perf_count_id_i(instr_perf_count_id_i), .rf_waddr_id_i(rf_waddr_id_i),
    .rf_we_id_i(rf_we_id_i), .rf_wcap_id_i(rf_wcap_id_i), .rf_wdata_int_id_i(rf_wdata_int_id_i),
    .rf_wdata_cap_id_i(rf_wdata_cap_id_i), .ready_wb_o(ready_wb_o),
    .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_resp_err_i(lsu_resp_err_i), .rf_we_lsu_i(rf_we_lsu_i),
    .rf_wcap_lsu_i(rf_wcap_lsu_i), .rf_wdata_int_lsu_i(rf_wdata_int_lsu_i),
    .rf_wdata_cap_lsu_i(rf_wdata_cap_lsu_i), .rf_raddr_a_i(rf_raddr_a_i), .rf_raddr_b_i(rf_raddr_b_i),
    .hazard_a_o(hazard_a_o), .hazard_b_o(hazard_b_o), .rf_waddr_wb_o(rf_waddr_wb_o),
    .rf_we_wb_o(rf_we_wb_o), .rf_wcap_wb_o(rf_wcap_wb_o), .rf_wdata_int_wb_o(rf_wdata_int_wb_o),
    .rf_wdata_cap_wb_o(rf_wdata_cap_wb_o), .instr_done_wb_o(instr_done_wb_o), .pc_wb_o(pc_wb_o),
    .pcc_wb_o(pcc_wb_o), .outstanding_load_wb_o(outstanding_load_wb_o),
    .outstanding_store_wb_o(outstanding_store_wb_o), .occupancy_o(occupancy_o),
    .perf_instr_ret_wb_o(perf_instr_ret_wb_o),
    .perf_instr_ret_compressed_wb_o(perf_instr_ret_compressed_wb_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [CW-1:0] rcap();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[CW-1:0];
  endfunction

  function automatic mentry_t apply_resp(mentry_t e, logic err, logic we, logic wcap,
                                         logic [31:0] di, logic [CW-1:0] dc);
    mentry_t r;
    r = e;
    r.done = 1'b1;
    r.err  = err;
    if (e.typ == T_LOAD) begin
      if (err) r.we = 1'b0;
      else begin r.we = we; r.wcap = wcap; r.di = di; r.dc = dc; end
    end
    return r;
  endfunction

  task automatic idle();
    en_wb_i = 0; instr_type_wb_i = T_OTHER; pc_id_i = 0; pcc_id_i = '0;
    instr_is_compressed_id_i = 0; instr_perf_count_id_i = 0; rf_waddr_id_i = 0;
    rf_we_id_i = 0; rf_wcap_id_i = 0; rf_wdata_int_id_i = 0; rf_wdata_cap_id_i = '0;
    lsu_resp_valid_i = 0; lsu_resp_err_i = 0; rf_we_lsu_i = 0; rf_wcap_lsu_i = 0;
    rf_wdata_int_lsu_i = 0; rf_wdata_cap_lsu_i = '0;
  endtask

  task automatic put(logic [1:0] t, logic [4:0] wa, logic we, logic [31:0] d);
    en_wb_i = 1; instr_type_wb_i = t; rf_waddr_id_i = wa; rf_we_id_i = we;
    rf_wdata_int_id_i = d; pc_id_i = 32'h100 + {27'd0, wa}; instr_perf_count_id_i = 1;
  endtask

  task automatic resp(logic err, logic we, logic wcap, logic [31:0] di, logic [CW-1:0] dc);
    lsu_resp_valid_i = 1; lsu_resp_err_i = err; rf_we_lsu_i = we; rf_wcap_lsu_i = wcap;
    rf_wdata_int_lsu_i = di; rf_wdata_cap_lsu_i = dc;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 0;
    rf_raddr_a_i = 5'd3; rf_raddr_b_i = 5'd4;
    @(negedge clk_i); #1;
    checks++; if (occupancy_o !== '0) begin errors++; $display("FAIL rst_occ: got %0d want 0", occupancy_o); end
    checks++; if (instr_done_wb_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", instr_done_wb_o); end
    checks++; if (rf_we_wb_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", rf_we_wb_o); end
    checks++; if (pcc_wb_o !== NULLCAP) begin errors++; $display("FAIL rst_pcc: got %h want %h", pcc_wb_o, NULLCAP); end
    checks++; if (pc_wb_o !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc_wb_o); end
    checks++; if ({outstanding_load_wb_o, outstanding_store_wb_o} !== 2'b00) begin errors++; $display("FAIL rst_outst: got %b want 00", {outstanding_load_wb_o, outstanding_store_wb_o}); end
    checks++; if ({hazard_a_o, hazard_b_o} !== 2'b00) begin errors++; $display("FAIL rst_hazard: got %b want 00", {hazard_a_o, hazard_b_o}); end
    @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i); #1;
    checks++; if (occupancy_o !== '0) begin errors++; $display("FAIL rst_occ_after: got %0d want 0", occupancy_o); end
    checks++; if (ready_wb_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %0b want 1", ready_wb_o); end
  endtask

  task automatic test_other_stream();
    logic [31:0] dat [3];
    dat[0] = 32'h11; dat[1] = 32'h22; dat[2] = 32'h33;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c < 3) put(T_OTHER, 5'(c + 1), 1'b1, dat[c]);
      #1;
      if (c < 3) begin
        checks++; if (ready_wb_o !== 1'b1) begin errors++; $display("FAIL other_ready[%0d]: got %0b want 1", c, ready_wb_o); end
      end
      if (c >= 1 && c <= 3) begin
        checks++; if (rf_we_wb_o !== 1'b1) begin errors++; $display("FAIL other_we[%0d]: got %0b want 1", c, rf_we_wb_o); end
        checks++; if (rf_waddr_wb_o !== 5'(c)) begin errors++; $display("FAIL other_waddr[%0d]: got %0d want %0d", c, rf_waddr_wb_o, c); end
        checks++; if (rf_wdata_int_wb_o !== dat[c-1]) begin errors++; $display("FAIL other_data[%0d]: got %h want %h", c, rf_wdata_int_wb_o, dat[c-1]); end
      end else begin
        checks++; if (rf_we_wb_o !== 1'b0) begin errors++; $display("FAIL other_idle_we[%0d]: got %0b want 0", c, rf_we_wb_o); end
      end
      if (c == 4) begin
        checks++; if (occupancy_o !== '0) begin errors++; $display("FAIL other_occ_end: got %0d want 0", occupancy_o); end
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_two_loads();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) put(T_LOAD, 5'd5, 1'b1, 32'h0);
      if (c == 1) put(T_LOAD, 5'd6, 1'b1, 32'h0);
      if (c == 2) resp(1'b0, 1'b1, 1'b0, 32'hAA, '0);
      if (c == 4) resp(1'b0, 1'b1, 1'b0, 32'hBB, '0);
      #1;
      if (c >= 1 && c <= 4) begin
        checks++; if (outstanding_load_wb_o !== 1'b1) begin errors++; $display("FAIL ld_outst[%0d]: got %0b want 1", c, outstanding_load_wb_o); end
      end
      if (c == 2 || c == 4) begin
        checks++; if (rf_we_wb_o !== 1'b1) begin errors++; $display("FAIL ld_we[%0d]: got %0b want 1", c, rf_we_wb_o); end
        checks++; if (rf_waddr_wb_o !== (c == 2 ? 5'd5 : 5'd6)) begin errors++; $display("FAIL ld_waddr[%0d]: got %0d", c, rf_waddr_wb_o); end
        checks++; if (rf_wdata_int_wb_o !== (c == 2 ? 32'hAA : 32'hBB)) begin errors++; $display("FAIL ld_data[%0d]: got %h", c, rf_wdata_int_wb_o); end
      end
      if (c == 3) begin
        checks++; if (instr_done_wb_o !== 1'b0) begin errors++; $display("FAIL ld_wait_done: got %0b want 0", instr_done_wb_o); end
      end
      if (c == 5) begin
        checks++; if (outstanding_load_wb_o !== 1'b0) begin errors++; $display("FAIL ld_outst_end: got %0b want 0", outstanding_load_wb_o); end
        checks++; if (occupancy_o !== '0) begin errors++; $display("FAIL ld_occ_end: got %0d want 0", occupancy_o); end
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_zero_latency_cap();
    logic [CW-1:0] cv;
    cv = rcap();
    do_reset();
    idle(); put(T_LOAD, 5'd7, 1'b0, 32'h0);
    @(negedge clk_i);
    idle(); resp(1'b0, 1'b1, 1'b1, 32'hCAFE, cv);
    #1;
    checks++; if (instr_done_wb_o !== 1'b1) begin errors++; $display("FAIL zl_done: got %0b want 1", instr_done_wb_o); end
    checks++; if (rf_we_wb_o !== 1'b1) begin errors++; $display("FAIL zl_we: got %0b want 1", rf_we_wb_o); end
    checks++; if (rf_wcap_wb_o !== 1'b1) begin errors++; $display("FAIL zl_wcap: got %0b want 1", rf_wcap_wb_o); end
    checks++; if (rf_waddr_wb_o !== 5'd7) begin errors++; $display("FAIL zl_waddr: got %0d want 7", rf_waddr_wb_o); end
    checks++; if (rf_wdata_int_wb_o !== 32'hCAFE) begin errors++; $display("FAIL zl_int: got %h want cafe", rf_wdata_int_wb_o); end
    checks++; if (rf_wdata_cap_wb_o !== cv) begin errors++; $display("FAIL zl_cap: got %h want %h", rf_wdata_cap_wb_o, cv); end
    @(negedge clk_i); idle(); #1;
    checks++; if (occupancy_o !== '0) begin errors++; $display("FAIL zl_occ: got %0d want 0", occupancy_o); end
  endtask

  task automatic test_load_error();
    do_reset();
    idle(); put(T_LOAD, 5'd8, 1'b1, 32'h0); instr_is_compressed_id_i = 1;
    @(negedge clk_i);
    idle(); resp(1'b1, 1'b1, 1'b0, 32'h1234, '0);
    #1;
    checks++; if (instr_done_wb_o !== 1'b1) begin errors++; $display("FAIL err_done: got %0b want 1", instr_done_wb_o); end
    checks++; if (rf_we_wb_o !== 1'b0) begin errors++; $display("FAIL err_we: got %0b want 0", rf_we_wb_o); end
    checks++; if (rf_wdata_int_wb_o !== 32'd0) begin errors++; $display("FAIL err_data: got %h want 0", rf_wdata_int_wb_o); end
    checks++; if (perf_instr_ret_wb_o !== 1'b0) begin errors++; $display("FAIL err_perf: got %0b want 0", perf_instr_ret_wb_o); end
    @(negedge clk_i); idle();
  endtask

  task automatic test_store_order();
    do_reset();
    rf_raddr_a_i = 5'd9; rf_raddr_b_i = 5'd0;
    for (int c = 0; c < 7; c++) begin
      idle();
      if (c == 0) put(T_STORE, 5'd0, 1'b0, 32'h0);
      if (c == 1) put(T_OTHER, 5'd9, 1'b1, 32'h99);
      if (c == 2 || c == 3) put(T_OTHER, 5'd10, 1'b1, 32'hA0);
      if (c == 3) resp(1'b0, 1'b0, 1'b0, 32'h0, '0);
      #1;
      if (c == 2) begin
        checks++; if (ready_wb_o !== 1'b0) begin errors++; $display("FAIL st_full_ready: got %0b want 0", ready_wb_o); end
        checks++; if (instr_done_wb_o !== 1'b0) begin errors++; $display("FAIL st_other_waits: got %0b want 0", instr_done_wb_o); end
        checks++; if (hazard_a_o !== 1'b1) begin errors++; $display("FAIL st_hazard_a: got %0b want 1", hazard_a_o); end
        checks++; if (hazard_b_o !== 1'b0) begin errors++; $display("FAIL st_hazard_b0: got %0b want 0", hazard_b_o); end
        checks++; if (outstanding_store_wb_o !== 1'b1) begin errors++; $display("FAIL st_outst: got %0b want 1", outstanding_store_wb_o); end
      end
      if (c == 3) begin
        checks++; if (ready_wb_o !== 1'b1) begin errors++; $display("FAIL st_full_retire_ready: got %0b want 1", ready_wb_o); end
        checks++; if ({instr_done_wb_o, rf_we_wb_o} !== 2'b10) begin errors++; $display("FAIL st_retire: got %b want 10", {instr_done_wb_o, rf_we_wb_o}); end
      end
      if (c == 4 || c == 5) begin
        checks++; if (rf_waddr_wb_o !== (c == 4 ? 5'd9 : 5'd10)) begin errors++; $display("FAIL st_order[%0d]: got %0d", c, rf_waddr_wb_o); end
      end
      if (c == 4) begin
        checks++; if (hazard_a_o !== 1'b0) begin errors++; $display("FAIL st_hazard_retiring: got %0b want 0", hazard_a_o); end
        checks++; if (occupancy_o !== OCCW'(2)) begin errors++; $display("FAIL st_occ: got %0d want 2", occupancy_o); end
      end
      if (c == 6) begin
        checks++; if (occupancy_o !== '0) begin errors++; $display("FAIL st_occ_end: got %0d want 0", occupancy_o); end
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    idle(); put(T_LOAD, 5'd11, 1'b1, 32'h0);
    @(negedge clk_i);
    idle(); put(T_LOAD, 5'd12, 1'b1, 32'h0);
    @(negedge clk_i);
    idle();
    #2 rst_ni = 0;
    #1;
    checks++; if (occupancy_o !== '0) begin errors++; $display("FAIL mid_rst_occ: got %0d want 0", occupancy_o); end
    checks++; if (outstanding_load_wb_o !== 1'b0) begin errors++; $display("FAIL mid_rst_outst: got %0b want 0", outstanding_load_wb_o); end
    resp(1'b0, 1'b1, 1'b0, 32'hDEAD, '0);
    #1;
    checks++; if ({rf_we_wb_o, instr_done_wb_o} !== 2'b00) begin errors++; $display("FAIL mid_rst_late_resp: got %b want 00", {rf_we_wb_o, instr_done_wb_o}); end
    @(negedge clk_i);
    idle(); rst_ni = 1;
    @(negedge clk_i); #1;
    checks++; if (occupancy_o !== '0) begin errors++; $display("FAIL mid_rst_occ_after: got %0d want 0", occupancy_o); end
    checks++; if (rf_we_wb_o !== 1'b0) begin errors++; $display("FAIL mid_rst_we_after: got %0b want 0", rf_we_wb_o); end
  endtask

  task automatic test_random(int n);
    mentry_t h, ne;
    int tgt;
    logic ret, exp_ready, exp_we, hz_a, hz_b, ol, os, exp_perf, exp_perfc;
    do_reset();
    mq.delete();
    for (int c = 0; c < n; c++) begin
      idle();
      en_wb_i = ($urandom_range(0, 9) < 6);
      instr_type_wb_i = 2'($urandom_range(0, 2));
      rf_waddr_id_i = 5'($urandom_range(0, 7));
      rf_we_id_i = 1'($urandom_range(0, 1));
      rf_wcap_id_i = 1'($urandom_range(0, 1));
      rf_wdata_int_id_i = $urandom();
      rf_wdata_cap_id_i = rcap();
      pc_id_i = $urandom();
      pcc_id_i = rcap();
      instr_is_compressed_id_i = 1'($urandom_range(0, 1));
      instr_perf_count_id_i = 1'($urandom_range(0, 1));
      rf_raddr_a_i = 5'($urandom_range(0, 7));
      rf_raddr_b_i = 5'($urandom_range(0, 7));
      tgt = -1;
      foreach (mq[i]) if (tgt < 0 && !mq[i].done && mq[i].typ != T_OTHER) tgt = i;
      if (tgt >= 0 && $urandom_range(0, 1) == 1)
        resp(($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), rcap());

      h = '0; ret = 0;
      if (mq.size() > 0) begin
        h = mq[0];
        if (lsu_resp_valid_i && tgt == 0)
          h = apply_resp(h, lsu_resp_err_i, rf_we_lsu_i, rf_wcap_lsu_i, rf_wdata_int_lsu_i, rf_wdata_cap_lsu_i);
        ret = h.done;
      end
      exp_ready = (mq.size() < DEPTH) || ret;
      exp_we = ret && h.we;
      hz_a = 0; hz_b = 0; ol = 0; os = 0;
      for (int i = (ret ? 1 : 0); i < mq.size(); i++) begin
        if (mq[i].waddr == rf_raddr_a_i && (mq[i].we || mq[i].typ == T_LOAD)) hz_a = 1;
        if (mq[i].waddr == rf_raddr_b_i && (mq[i].we || mq[i].typ == T_LOAD)) hz_b = 1;
      end
      hz_a = hz_a && (rf_raddr_a_i != 0);
      hz_b = hz_b && (rf_raddr_b_i != 0);
      foreach (mq[i]) begin
        if (!mq[i].done && mq[i].typ == T_LOAD) ol = 1;
        if (!mq[i].done && mq[i].typ == T_STORE) os = 1;
      end
`ifdef IBEX_WB_QUEUE_PERF_EN
      exp_perf = ret && h.cnt && !h.err;
      exp_perfc = exp_perf && h.cmp;
`else
      exp_perf = 0;
      exp_perfc = 0;
`endif
      #1;
      checks++; if (ready_wb_o !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", c, ready_wb_o, exp_ready); end
      checks++; if (instr_done_wb_o !== ret) begin errors++; $display("FAIL rnd_done[%0d]: got %0b want %0b", c, instr_done_wb_o, ret); end
      checks++; if (rf_we_wb_o !== exp_we) begin errors++; $display("FAIL rnd_we[%0d]: got %0b want %0b", c, rf_we_wb_o, exp_we); end
      checks++; if (rf_wdata_int_wb_o !== (exp_we ? h.di : 32'd0)) begin errors++; $display("FAIL rnd_int[%0d]: got %h want %h", c, rf_wdata_int_wb_o, exp_we ? h.di : 32'd0); end
      checks++; if (rf_wdata_cap_wb_o !== (exp_we ? h.dc : '0)) begin errors++; $display("FAIL rnd_cap[%0d]: got %h", c, rf_wdata_cap_wb_o); end
      if (ret) begin
        checks++; if (rf_waddr_wb_o !== h.waddr) begin errors++; $display("FAIL rnd_waddr[%0d]: got %0d want %0d", c, rf_waddr_wb_o, h.waddr); end
      end
      if (exp_we) begin
        checks++; if (rf_wcap_wb_o !== h.wcap) begin errors++; $display("FAIL rnd_wcap[%0d]: got %0b want %0b", c, rf_wcap_wb_o, h.wcap); end
      end
      checks++; if (pc_wb_o !== (mq.size() > 0 ? mq[0].pc : 32'd0)) begin errors++; $display("FAIL rnd_pc[%0d]: got %h", c, pc_wb_o); end
      checks++; if (pcc_wb_o !== (mq.size() > 0 ? mq[0].pcc : NULLCAP)) begin errors++; $display("FAIL rnd_pcc[%0d]: got %h", c, pcc_wb_o); end
      checks++; if ({hazard_a_o, hazard_b_o} !== {hz_a, hz_b}) begin errors++; $display("FAIL rnd_hazard[%0d]: got %b want %b", c, {hazard_a_o, hazard_b_o}, {hz_a, hz_b}); end
      checks++; if ({outstanding_load_wb_o, outstanding_store_wb_o} !== {ol, os}) begin errors++; $display("FAIL rnd_outst[%0d]: got %b want %b", c, {outstanding_load_wb_o, outstanding_store_wb_o}, {ol, os}); end
      checks++; if (occupancy_o !== OCCW'(mq.size())) begin errors++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", c, occupancy_o, mq.size()); end
      checks++; if ({perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o} !== {exp_perf, exp_perfc}) begin errors++; $display("FAIL rnd_perf[%0d]: got %b want %b", c, {perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o}, {exp_perf, exp_perfc}); end

      if (lsu_resp_valid_i)
        mq[tgt] = apply_resp(mq[tgt], lsu_resp_err_i, rf_we_lsu_i, rf_wcap_lsu_i, rf_wdata_int_lsu_i, rf_wdata_cap_lsu_i);
      if (ret) void'(mq.pop_front());
      if (en_wb_i && exp_ready) begin
        ne.typ = instr_type_wb_i; ne.waddr = rf_waddr_id_i; ne.we = rf_we_id_i; ne.wcap = rf_wcap_id_i;
        ne.di = rf_wdata_int_id_i; ne.dc = rf_wdata_cap_id_i; ne.pc = pc_id_i; ne.pcc = pcc_id_i;
        ne.cmp = instr_is_compressed_id_i; ne.cnt = instr_perf_count_id_i;
        ne.done = (instr_type_wb_i == T_OTHER); ne.err = 0;
        mq.push_back(ne);
      end
      @(negedge clk_i);
    end
    idle();
  endtask

  initial begin
    idle();
    rf_raddr_a_i = 0;
    rf_raddr_b_i = 0;
    test_reset();
    test_other_stream();
    test_two_loads();
    test_zero_latency_cap();
    test_load_error();
    test_store_order();
    test_reset_midop();
    test_random(400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
